// File: rtl/mac_sat_vec.sv
// Pipelined saturating multiply-accumulate over signed fixed-point vectors.
// One element per cycle; a vector ends on last_in or after MAX_LEN elements.
module mac_sat_vec #(
  parameter int IN_W    = 14,
  parameter int ACC_W   = 28,
  parameter int PIPE    = 1,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic                    valid_in,
  input  logic                    last_in,
  output logic signed [ACC_W-1:0] f,
  output logic                    valid_out,
  output logic                    sat_out,
  output logic [CNT_W-1:0]        len_out
);

  localparam int PROD_W = 2 * IN_W;

  logic signed [IN_W-1:0]   a_reg, b_reg;
  logic                     v0_reg, l0_reg;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] prod_s;
  logic                     v_acc, l_acc;

  logic signed [ACC_W-1:0]  acc_reg;
  logic                     sticky_reg;
  logic [CNT_W-1:0]         cnt_reg;

  logic signed [ACC_W-1:0]  p_ext;
  logic signed [ACC_W:0]    sum;
  logic                     ovf_pos, ovf_neg, clip;
  logic signed [ACC_W-1:0]  clamped;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     term;

  // Operand capture; operands hold across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= '0;
      b_reg  <= '0;
      v0_reg <= 1'b0;
      l0_reg <= 1'b0;
    end else begin
      v0_reg <= valid_in;
      l0_reg <= valid_in & last_in;
      if (valid_in) begin
        a_reg <= a;
        b_reg <= b;
      end
    end
  end

  assign prod_c = PROD_W'(a_reg) * PROD_W'(b_reg);

  generate
    if (PIPE == 1) begin : g_pipe
      logic signed [PROD_W-1:0] prod_reg;
      logic                     v1_reg, l1_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          prod_reg <= '0;
          v1_reg   <= 1'b0;
          l1_reg   <= 1'b0;
        end else begin
          prod_reg <= prod_c;
          v1_reg   <= v0_reg;
          l1_reg   <= l0_reg;
        end
      end

      assign prod_s = prod_reg;
      assign v_acc  = v1_reg;
      assign l_acc  = l1_reg;
    end else begin : g_nopipe
      assign prod_s = prod_c;
      assign v_acc  = v0_reg;
      assign l_acc  = l0_reg;
    end
  endgenerate

  // One guard bit: overflow shows as disagreement between the top two sum bits.
  always_comb begin
    p_ext   = ACC_W'(prod_s);
    sum     = (ACC_W + 1)'(acc_reg) + (ACC_W + 1)'(p_ext);
    ovf_pos = ~sum[ACC_W] & sum[ACC_W-1];
    ovf_neg = sum[ACC_W] & ~sum[ACC_W-1];
    clip    = ovf_pos | ovf_neg;
    if (ovf_pos)
      clamped = {1'b0, {(ACC_W - 1){1'b1}}};
    else if (ovf_neg)
      clamped = {1'b1, {(ACC_W - 1){1'b0}}};
    else
      clamped = sum[ACC_W-1:0];
    cnt_inc = cnt_reg + CNT_W'(1);
    term    = l_acc | (cnt_inc == CNT_W'(MAX_LEN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg    <= '0;
      sticky_reg <= 1'b0;
      cnt_reg    <= '0;
      f          <= '0;
      valid_out  <= 1'b0;
      sat_out    <= 1'b0;
      len_out    <= '0;
    end else begin
      valid_out <= 1'b0;
      if (v_acc) begin
        if (term) begin
          f          <= clamped;
          sat_out    <= sticky_reg | clip;
          len_out    <= cnt_inc;
          valid_out  <= 1'b1;
          acc_reg    <= '0;
          sticky_reg <= 1'b0;
          cnt_reg    <= '0;
        end else begin
          acc_reg    <= clamped;
          sticky_reg <= sticky_reg | clip;
          cnt_reg    <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_sat_vec.sv
// Drives three mac_sat_vec configurations with shared stimulus and compares each
// against an arithmetic dot-product model with per-cycle output expectations.
module tb_mac_sat_vec;

  localparam int IN_W  = 14;
  localparam int ACC_W = 28;
  localparam longint SMAX = (64'sd1 <<< (ACC_W - 1)) - 1;
  localparam longint SMIN = -(64'sd1 <<< (ACC_W - 1));

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [IN_W-1:0] a = '0, b = '0;
  logic valid_in = 1'b0, last_in = 1'b0;

  logic signed [ACC_W-1:0] f0, f1, f2;
  logic v0, v1, v2, s0, s1, s2;
  logic [4:0] l0, l1;
  logic [2:0] l2;

  // d0: PIPE=1 MAX_LEN=16, d1: PIPE=0 MAX_LEN=16, d2: PIPE=1 MAX_LEN=4
  mac_sat_vec #(.IN_W(IN_W), .ACC_W(ACC_W), .PIPE(1), .MAX_LEN(16)) dut0 (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .last_in(last_in),
    .f(f0), .valid_out(v0), .sat_out(s0), .len_out(l0));
  mac_sat_vec #(.IN_W(IN_W), .ACC_W(ACC_W), .PIPE(0), .MAX_LEN(16)) dut1 (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .last_in(last_in),
    .f(f1), .valid_out(v1), .sat_out(s1), .len_out(l1));
  mac_sat_vec #(.IN_W(IN_W), .ACC_W(ACC_W), .PIPE(1), .MAX_LEN(4)) dut2 (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .last_in(last_in),
    .f(f2), .valid_out(v2), .sat_out(s2), .len_out(l2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  // Reference state: running vector per config, pending results keyed by due cycle.
  longint m_acc [3];
  bit     m_sat [3];
  int     m_cnt [3];
  bit     pend_v [3][8];
  longint pend_f [3][8];
  bit     pend_s [3][8];
  int     pend_l [3][8];
  longint hold_f [3];
  bit     hold_s [3];
  int     hold_l [3];

  function automatic int pipe_of(input int d);
    return (d == 1) ? 0 : 1;
  endfunction

  function automatic int maxlen_of(input int d);
    return (d == 2) ? 4 : 16;
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_acc[d] = 0; m_sat[d] = 0; m_cnt[d] = 0;
      hold_f[d] = 0; hold_s[d] = 0; hold_l[d] = 0;
      for (int k = 0; k < 8; k++) pend_v[d][k] = 0;
    end
  endtask

  task automatic model_elem(input longint av, input longint bv, input bit last);
    longint s;
    int slot;
    for (int d = 0; d < 3; d++) begin
      s = m_acc[d] + av * bv;
      if (s > SMAX) begin s = SMAX; m_sat[d] = 1; end
      else if (s < SMIN) begin s = SMIN; m_sat[d] = 1; end
      m_acc[d] = s;
      m_cnt[d]++;
      if (last || m_cnt[d] == maxlen_of(d)) begin
        slot = (cyc + 2 + pipe_of(d)) % 8;
        pend_v[d][slot] = 1;
        pend_f[d][slot] = s;
        pend_s[d][slot] = m_sat[d];
        pend_l[d][slot] = m_cnt[d];
        m_acc[d] = 0; m_sat[d] = 0; m_cnt[d] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    bit ov, os;
    longint of;
    int ol, slot;
    bit ev;
    slot = cyc % 8;
    for (int d = 0; d < 3; d++) begin
      case (d)
        0: begin ov = v0; of = longint'(f0); os = s0; ol = int'(l0); end
        1: begin ov = v1; of = longint'(f1); os = s1; ol = int'(l1); end
        default: begin ov = v2; of = longint'(f2); os = s2; ol = int'(l2); end
      endcase
      ev = pend_v[d][slot];
      if (ev) begin
        hold_f[d] = pend_f[d][slot];
        hold_s[d] = pend_s[d][slot];
        hold_l[d] = pend_l[d][slot];
        pend_v[d][slot] = 0;
      end
      check($sformatf("d%0d valid_out", d), longint'(ov), longint'(ev));
      check($sformatf("d%0d f", d), of, hold_f[d]);
      check($sformatf("d%0d sat_out", d), longint'(os), longint'(hold_s[d]));
      check($sformatf("d%0d len_out", d), longint'(ol), longint'(hold_l[d]));
      if (ev)
        $display("cyc %0d d%0d result f=%0d sat=%0d len=%0d", cyc, d, of, os, ol);
    end
  endtask

  task automatic drive(input bit v, input int av, input int bv, input bit last);
    @(negedge clk);
    check_outputs();
    reset    = 1'b0;
    valid_in = v;
    last_in  = last;
    a        = IN_W'(av);
    b        = IN_W'(bv);
    if (v) model_elem(longint'(av), longint'(bv), last);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    reset    = 1'b1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    model_reset();
  endtask

  function automatic int rand_op();
    case ($urandom_range(0, 5))
      0: return -8192;
      1: return 8191;
      2: return $urandom_range(0, 15) - 8;
      default: return int'($urandom_range(0, 16383)) - 8192;
    endcase
  endfunction

  initial begin
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // basic vector, back-to-back
    drive(1, 2, 3, 0); drive(1, -4, 5, 0); drive(1, 7, 7, 1);
    idle(4);
    // same vector with gaps
    drive(1, 2, 3, 0); idle(2); drive(1, -4, 5, 0); idle(1); drive(1, 7, 7, 1);
    idle(4);
    // positive saturation then an immediately following clean vector
    drive(1, -8192, -8192, 0); drive(1, -8192, -8192, 1); drive(1, 1, 1, 1);
    idle(4);
    // negative saturation, continuing from the clamped value
    drive(1, -8192, 8191, 0); drive(1, -8192, 8191, 0); drive(1, -8192, 8191, 0);
    drive(1, 1, 1, 1);
    idle(4);
    // auto-terminate on the MAX_LEN=4 instance
    for (int i = 0; i < 6; i++) drive(1, 1, 1, i == 5);
    idle(4);
    // reset mid-vector, and with a terminating element in flight
    drive(1, 5, 5, 0); drive(1, 2, 2, 0);
    do_reset();
    drive(1, 1, 1, 0); drive(1, 2, 2, 1);
    do_reset();
    idle(4);
    drive(1, 3, 3, 1);
    idle(4);

    // randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else drive($urandom_range(0, 9) < 7, rand_op(), rand_op(), $urandom_range(0, 5) == 0);
    end
    idle(6);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
